// File: rtl/simmem_pkg.sv
// Packet types and sizing shared by the simulated memory controller and its responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package simmem_pkg;

  localparam int unsigned IdWidth              = 4;
  localparam int unsigned AddrWidth            = 20;
  localparam int unsigned BurstLenWidth        = 3;
  localparam int unsigned MaxBurstLenField     = 2;
  localparam int unsigned XRespWidth           = 10;
  localparam int unsigned MaxBurstEffSizeBytes = 16;
  localparam int unsigned WStrbWidth           = 4;
  localparam int unsigned DataWidth            = MaxBurstEffSizeBytes;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_len;
  } waddr_t;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_len;
  } raddr_t;

  typedef struct packed {
    logic [DataWidth-1:0]  data;
    logic [WStrbWidth-1:0] strb;
    logic                  last;
  } wdata_t;

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [XRespWidth-1:0] rsp;
  } wrsp_t;

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [DataWidth-1:0]  data;
    logic [WStrbWidth-1:0] response;
    logic                  last;
  } rdata_t;

endpackage

// File: rtl/simmem_axi_responder.sv
// Behavioural memory stand-in: answers write bursts with one response and read addresses with data bursts.
// Latency: read beat 0 one cycle after raddr accept; wrsp one cycle after the final wdata beat.
// Backpressure: address ready drops when its FIFO is full; a final wdata beat stalls while wrsp is occupied and not drained.
module simmem_axi_responder
  import simmem_pkg::*;
#(
  parameter int unsigned WAddrQueueDepth = 4,
  parameter int unsigned RAddrQueueDepth = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  waddr_t waddr_i,
  input  logic   waddr_in_valid_i,
  output logic   waddr_in_ready_o,
  input  wdata_t wdata_i,
  input  logic   wdata_in_valid_i,
  output logic   wdata_in_ready_o,
  output wrsp_t  wrsp_o,
  output logic   wrsp_out_valid_o,
  input  logic   wrsp_out_ready_i,
  input  raddr_t raddr_i,
  input  logic   raddr_in_valid_i,
  output logic   raddr_in_ready_o,
  output rdata_t rdata_o,
  output logic   rdata_out_valid_o,
  input  logic   rdata_out_ready_i
);

  localparam int unsigned WPtrW = $clog2(WAddrQueueDepth);
  localparam int unsigned RPtrW = $clog2(RAddrQueueDepth);
  localparam int unsigned CntW  = MaxBurstLenField + 1;

  localparam logic [WPtrW:0]  WPtrOne = {{WPtrW{1'b0}}, 1'b1};
  localparam logic [RPtrW:0]  RPtrOne = {{RPtrW{1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};

  // Index of the final beat: burst field clamped so oversize values never wrap to a short burst.
  function automatic logic [CntW-1:0] last_beat_idx(input logic [BurstLenWidth-1:0] len);
    int unsigned sh;
    if (32'(len) > MaxBurstLenField) sh = MaxBurstLenField;
    else                             sh = 32'(len);
    return (CntOne << sh) - CntOne;
  endfunction

  // ---------------- write path ----------------
  waddr_t           wq_mem_q [WAddrQueueDepth];
  logic [WPtrW:0]   wq_wptr_q, wq_wptr_d, wq_rptr_q, wq_rptr_d;
  logic [CntW-1:0]  wcnt_q, wcnt_d;
  logic             wrsp_vld_q, wrsp_vld_d;
  wrsp_t            wrsp_dat_q, wrsp_dat_d;
  waddr_t           wq_head;
  logic             wq_empty, wq_full, w_final, waddr_hs, wdata_hs, w_done, wrsp_hs;

  assign wq_head  = wq_mem_q[wq_rptr_q[WPtrW-1:0]];
  assign wq_empty = (wq_wptr_q == wq_rptr_q);
  assign wq_full  = (wq_wptr_q[WPtrW] != wq_rptr_q[WPtrW]) &&
                    (wq_wptr_q[WPtrW-1:0] == wq_rptr_q[WPtrW-1:0]);

  assign w_final  = (wcnt_q == last_beat_idx(wq_head.burst_len)) || wdata_i.last;

  assign waddr_in_ready_o = !wq_full;
  assign wdata_in_ready_o = !wq_empty && !(w_final && wrsp_vld_q && !wrsp_out_ready_i);
  assign wrsp_out_valid_o = wrsp_vld_q;
  assign wrsp_o           = wrsp_vld_q ? wrsp_dat_q : '0;

  assign waddr_hs = waddr_in_valid_i && waddr_in_ready_o;
  assign wdata_hs = wdata_in_valid_i && wdata_in_ready_o;
  assign w_done   = wdata_hs && w_final;
  assign wrsp_hs  = wrsp_vld_q && wrsp_out_ready_i;

  // Write-side next state: FIFO pointers, beat counter, and the response register (reload beats clear).
  always_comb begin
    wq_wptr_d  = wq_wptr_q;
    wq_rptr_d  = wq_rptr_q;
    wcnt_d     = wcnt_q;
    wrsp_vld_d = wrsp_vld_q;
    wrsp_dat_d = wrsp_dat_q;
    if (waddr_hs) wq_wptr_d = wq_wptr_q + WPtrOne;
    if (wdata_hs) begin
      if (w_final) begin
        wq_rptr_d = wq_rptr_q + WPtrOne;
        wcnt_d    = '0;
      end else begin
        wcnt_d    = wcnt_q + CntOne;
      end
    end
    if (w_done) begin
      wrsp_vld_d = 1'b1;
      wrsp_dat_d = '{id: wq_head.id, rsp: wq_head.addr[XRespWidth-1:0]};
    end else if (wrsp_hs) begin
      wrsp_vld_d = 1'b0;
    end
  end

  // Write-side state registers; reset abandons queued and partial bursts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wq_wptr_q  <= '0;
      wq_rptr_q  <= '0;
      wcnt_q     <= '0;
      wrsp_vld_q <= 1'b0;
      wrsp_dat_q <= '0;
    end else begin
      wq_wptr_q  <= wq_wptr_d;
      wq_rptr_q  <= wq_rptr_d;
      wcnt_q     <= wcnt_d;
      wrsp_vld_q <= wrsp_vld_d;
      wrsp_dat_q <= wrsp_dat_d;
    end
  end

  // Write-address storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (waddr_hs) wq_mem_q[wq_wptr_q[WPtrW-1:0]] <= waddr_i;
  end

  // ---------------- read path ----------------
  raddr_t           rq_mem_q [RAddrQueueDepth];
  logic [RPtrW:0]   rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
  logic [CntW-1:0]  rcnt_q, rcnt_d;
  raddr_t           rq_head;
  logic             rq_empty, rq_full, r_last, raddr_hs, rdata_hs;

  assign rq_head  = rq_mem_q[rq_rptr_q[RPtrW-1:0]];
  assign rq_empty = (rq_wptr_q == rq_rptr_q);
  assign rq_full  = (rq_wptr_q[RPtrW] != rq_rptr_q[RPtrW]) &&
                    (rq_wptr_q[RPtrW-1:0] == rq_rptr_q[RPtrW-1:0]);
  assign r_last   = (rcnt_q == last_beat_idx(rq_head.burst_len));

  assign raddr_in_ready_o  = !rq_full;
  assign rdata_out_valid_o = !rq_empty;
  assign raddr_hs          = raddr_in_valid_i && raddr_in_ready_o;
  assign rdata_hs          = rdata_out_valid_o && rdata_out_ready_i;

  // Read beat is a pure function of the head request and beat index; zeros when idle.
  always_comb begin
    rdata_o = '0;
    if (!rq_empty) begin
      rdata_o.id       = rq_head.id;
      rdata_o.data     = rq_head.addr[MaxBurstEffSizeBytes-1:0] + DataWidth'(rcnt_q);
      rdata_o.response = WStrbWidth'(rcnt_q);
      rdata_o.last     = r_last;
    end
  end

  // Read-side next state: pop and rewind the beat counter on the last-beat handshake.
  always_comb begin
    rq_wptr_d = rq_wptr_q;
    rq_rptr_d = rq_rptr_q;
    rcnt_d    = rcnt_q;
    if (raddr_hs) rq_wptr_d = rq_wptr_q + RPtrOne;
    if (rdata_hs) begin
      if (r_last) begin
        rq_rptr_d = rq_rptr_q + RPtrOne;
        rcnt_d    = '0;
      end else begin
        rcnt_d    = rcnt_q + CntOne;
      end
    end
  end

  // Read-side state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rq_wptr_q <= '0;
      rq_rptr_q <= '0;
      rcnt_q    <= '0;
    end else begin
      rq_wptr_q <= rq_wptr_d;
      rq_rptr_q <= rq_rptr_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Read-address storage.
  always_ff @(posedge clk_i) begin
    if (raddr_hs) rq_mem_q[rq_wptr_q[RPtrW-1:0]] <= raddr_i;
  end

endmodule

// File: tb/tb_simmem_axi_responder.sv
// Bench for simmem_axi_responder: directed scenarios plus random traffic against a queue-level model.
// Latency: model predicts each cycle's outputs from the requests accepted so far.
// Backpressure: readies on both response channels are driven randomly in the random phase.
module tb_simmem_axi_responder;
  import simmem_pkg::*;

  localparam int WDEPTH = 4;
  localparam int RDEPTH = 4;

  logic   clk, rst_n;
  waddr_t aw;  logic aw_v;
  wdata_t wd;  logic wd_v;
  logic   b_rdy;
  raddr_t ar;  logic ar_v;
  logic   r_rdy;

  logic   waddr_in_ready_o, wdata_in_ready_o, wrsp_out_valid_o, raddr_in_ready_o, rdata_out_valid_o;
  wrsp_t  wrsp_o;
  rdata_t rdata_o;

  simmem_axi_responder #(.WAddrQueueDepth(WDEPTH), .RAddrQueueDepth(RDEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .waddr_i(aw), .waddr_in_valid_i(aw_v), .waddr_in_ready_o(waddr_in_ready_o),
    .wdata_i(wd), .wdata_in_valid_i(wd_v), .wdata_in_ready_o(wdata_in_ready_o),
    .wrsp_o(wrsp_o), .wrsp_out_valid_o(wrsp_out_valid_o), .wrsp_out_ready_i(b_rdy),
    .raddr_i(ar), .raddr_in_valid_i(ar_v), .raddr_in_ready_o(raddr_in_ready_o),
    .rdata_o(rdata_o), .rdata_out_valid_o(rdata_out_valid_o), .rdata_out_ready_i(r_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted requests in order, plus the beat index inside each head burst.
  waddr_t wq[$];
  raddr_t rq[$];
  wrsp_t  bq[$];
  int     wbeat, rbeat;

  function automatic int burst_beats(input logic [BurstLenWidth-1:0] len);
    int l = int'(len);
    if (l > int'(MaxBurstLenField)) l = int'(MaxBurstLenField);
    return 1 << l;
  endfunction

  task automatic model_reset();
    wq.delete(); rq.delete(); bq.delete();
    wbeat = 0; rbeat = 0;
  endtask

  // Called away from clock edges with this cycle's inputs applied: check, predict, advance.
  task automatic tick();
    waddr_t wh; raddr_t rh; wrsp_t ew; rdata_t er;
    bit awr, arr, wfin, ewr, wdone;
    #1;
    wh = '0; rh = '0;
    awr = (wq.size() < WDEPTH);
    arr = (rq.size() < RDEPTH);
    wfin = 0; ewr = 0;
    if (wq.size() > 0) begin
      wh   = wq[0];
      wfin = (wbeat == burst_beats(wh.burst_len) - 1) || wd.last;
      ewr  = !(wfin && bq.size() > 0 && !b_rdy);
    end
    ew = (bq.size() > 0) ? bq[0] : '0;
    er = '0;
    if (rq.size() > 0) begin
      rh          = rq[0];
      er.id       = rh.id;
      er.data     = rh.addr[DataWidth-1:0] + DataWidth'(rbeat);
      er.response = WStrbWidth'(rbeat);
      er.last     = (rbeat == burst_beats(rh.burst_len) - 1);
    end
    chk("awready", 64'(waddr_in_ready_o),  64'(awr));
    chk("arready", 64'(raddr_in_ready_o),  64'(arr));
    chk("wready",  64'(wdata_in_ready_o),  64'(ewr));
    chk("bvalid",  64'(wrsp_out_valid_o),  64'(bq.size() > 0));
    chk("bdata",   64'(wrsp_o),            64'(ew));
    chk("rvalid",  64'(rdata_out_valid_o), 64'(rq.size() > 0));
    chk("rdata",   64'(rdata_o),           64'(er));
    if (rst_n) begin
      wdone = wd_v && ewr && wfin;
      if (wd_v && ewr) begin
        if (wfin) begin void'(wq.pop_front()); wbeat = 0; end
        else wbeat++;
      end
      if (bq.size() > 0 && b_rdy) void'(bq.pop_front());
      if (wdone) bq.push_back('{id: wh.id, rsp: wh.addr[XRespWidth-1:0]});
      if (rq.size() > 0 && r_rdy) begin
        if (er.last) begin void'(rq.pop_front()); rbeat = 0; end
        else rbeat++;
      end
      if (aw_v && awr) wq.push_back(aw);
      if (ar_v && arr) rq.push_back(ar);
    end
    @(negedge clk);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    aw = '0; aw_v = 0; wd = '0; wd_v = 0; b_rdy = 0; ar = '0; ar_v = 0; r_rdy = 0;
    model_reset();
    @(negedge clk);
    tick(); tick();
    chk("rst_awrdy", 64'(waddr_in_ready_o), 64'd1);
    chk("rst_wrdy",  64'(wdata_in_ready_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o),          64'd0);
    rst_n = 1'b1;
    tick();

    // Single read: 4 beats, data 5..8, last on beat 3.
    ar = '{id: 4'd2, addr: 20'h00005, burst_len: 3'd2}; ar_v = 1; tick(); ar_v = 0;
    r_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("plan_rd_data", 64'(rdata_o.data),     64'(5 + i));
      chk("plan_rd_resp", 64'(rdata_o.response), 64'(i));
      chk("plan_rd_last", 64'(rdata_o.last),     64'(i == 3));
      chk("plan_rd_id",   64'(rdata_o.id),       64'd2);
      tick();
    end
    tick();

    // Clamp: burst field 7 gives 4 beats, 0 gives a single last beat.
    ar = '{id: 4'd3, addr: 20'h00100, burst_len: 3'd7}; ar_v = 1; tick(); ar_v = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin #1; if (rdata_out_valid_o) n++; tick(); end
    chk("clamp7_beats", 64'(n), 64'd4);
    ar = '{id: 4'd4, addr: 20'h00200, burst_len: 3'd0}; ar_v = 1; tick(); ar_v = 0;
    #1; chk("clamp0_last", 64'(rdata_o.last), 64'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin #1; if (rdata_out_valid_o) n++; tick(); end
    chk("clamp0_beats", 64'(n), 64'd1);

    // Write with early last, then a full 4-beat burst.
    b_rdy = 1;
    aw = '{id: 4'd1, addr: 20'h003FF, burst_len: 3'd2}; aw_v = 1; tick(); aw_v = 0;
    wd_v = 1; wd = '{data: 16'h1111, strb: 4'hF, last: 1'b0}; tick();
    wd.last = 1; tick(); wd_v = 0; wd.last = 0;
    #1;
    chk("early_bvalid", 64'(wrsp_out_valid_o), 64'd1);
    chk("early_bid",    64'(wrsp_o.id),        64'd1);
    chk("early_brsp",   64'(wrsp_o.rsp),       64'h3FF);
    tick(); tick();
    aw = '{id: 4'd3, addr: 20'h12345, burst_len: 3'd2}; aw_v = 1; tick(); aw_v = 0;
    wd_v = 1;
    for (int i = 0; i < 4; i++) tick();
    wd_v = 0;
    #1; chk("second_bid", 64'(wrsp_o.id), 64'd3);
    tick(); tick();

    // Backpressure: held response blocks the next final beat.
    b_rdy = 0;
    aw = '{id: 4'd4, addr: 20'h00044, burst_len: 3'd0}; aw_v = 1; tick();
    aw = '{id: 4'd5, addr: 20'h00055, burst_len: 3'd0}; tick(); aw_v = 0;
    wd_v = 1; wd.last = 1; tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_wrdy", 64'(wdata_in_ready_o), 64'd0);
      chk("bp_hold", 64'(wrsp_o.id),        64'd4);
      tick();
    end
    b_rdy = 1;
    tick(); wd_v = 0; wd.last = 0;
    #1; chk("bp_second_id", 64'(wrsp_o.id), 64'd5);
    tick(); tick();

    // Fill the read FIFO while stalled, then drain back to back.
    r_rdy = 0;
    for (int i = 0; i < RDEPTH; i++) begin
      ar = '{id: 4'(i + 8), addr: 20'($urandom), burst_len: 3'($urandom_range(0, 7))};
      ar_v = 1; tick();
    end
    ar_v = 0;
    #1; chk("fill_arrdy", 64'(raddr_in_ready_o), 64'd0);
    r_rdy = 1;
    for (int i = 0; i < 40 && rq.size() > 0; i++) tick();
    chk("fill_drained", 64'(rq.size()), 64'd0);

    // Asynchronous reset after beat 1 of a read burst.
    ar = '{id: 4'd6, addr: 20'h00020, burst_len: 3'd2}; ar_v = 1; tick(); ar_v = 0;
    tick(); tick();
    rst_n = 0; r_rdy = 0; model_reset();
    #1;
    chk("arst_rvalid", 64'(rdata_out_valid_o), 64'd0);
    chk("arst_rdata",  64'(rdata_o),           64'd0);
    chk("arst_arrdy",  64'(raddr_in_ready_o),  64'd1);
    tick();
    rst_n = 1;
    ar = '{id: 4'd7, addr: 20'h00040, burst_len: 3'd1}; ar_v = 1; tick(); ar_v = 0;
    #1;
    chk("post_rst_data", 64'(rdata_o.data),     64'h40);
    chk("post_rst_resp", 64'(rdata_o.response), 64'd0);
    r_rdy = 1; tick(); tick(); tick();

    // Random traffic on both paths.
    for (int c = 0; c < 3000; c++) begin
      aw_v  = ($urandom_range(0, 2) == 0);
      aw    = '{id: 4'($urandom), addr: 20'($urandom), burst_len: 3'($urandom_range(0, 7))};
      wd_v  = ($urandom_range(0, 2) != 0);
      wd    = '{data: 16'($urandom), strb: 4'($urandom), last: ($urandom_range(0, 5) == 0)};
      b_rdy = ($urandom_range(0, 3) != 0);
      ar_v  = ($urandom_range(0, 2) == 0);
      ar    = '{id: 4'($urandom), addr: 20'($urandom), burst_len: 3'($urandom_range(0, 7))};
      r_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
